// File: rtl/i2c_target_rx.sv
// i2c_target_rx
// I2C target (responder) that sits at the far end of the board's I2C master.
// It watches SCL/SDA, recognises START / repeated START / STOP, answers to a
// 7-bit address, hands written bytes to the fabric and serves read bytes from
// the fabric. SDA is driven open-drain through an enable. SCL is never stretched.
//
// Ports:
//   clk       system clock, at least 8x the SCL rate
//   rst_n     asynchronous active-low reset
//   scl_i     raw SCL pin
//   sda_i     raw SDA pin
//   sda_o_en  1 = pull SDA low, 0 = release
//   rx_data   last byte written by the master
//   rx_valid  one-clk pulse when rx_data updates
//   tx_data   byte to return on a read, sampled while tx_req is high
//   tx_req    one-clk request for the next read byte
//   busy      high from an address match until STOP (or a START that fails to re-match)
//
// Optional feature macro: I2C_TGT_GLITCH_FILTER_EN
//   Adds a 3-sample majority filter behind the synchronizers on SCL and SDA,
//   suppressing 1-clk pulses at the cost of two extra clocks of latency.
module i2c_target_rx #(
    parameter logic [6:0] ADDR        = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_BYTE,
        ST_WR_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic                   sclClean, sdaClean;
    logic                   sclPrev_q, sdaPrev_q;
    logic                   sclRise, sclFall, startDet, stopDet;

    state_t     state_q, state_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d, shiftIn;
    logic       rw_q, rw_d;
    logic       sdaOen_q, sdaOen_d;
    logic [7:0] rxData_q, rxData_d;
    logic       rxValid_q, rxValid_d;
    logic       txReq_q, txReq_d;
    logic       busy_q, busy_d;

    // Preset to 1 so an idle bus produces no edges when reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] sclHist_q, sdaHist_q;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclHist_q <= '1;
            sdaHist_q <= '1;
        end else begin
            sclHist_q <= {sclHist_q[1:0], sclSync_q[SYNC_STAGES-1]};
            sdaHist_q <= {sdaHist_q[1:0], sdaSync_q[SYNC_STAGES-1]};
        end
    end

    // Majority is combinational so the filter adds exactly two clocks.
    assign sclClean = majority3(sclHist_q);
    assign sdaClean = majority3(sdaHist_q);
`else
    assign sclClean = sclSync_q[SYNC_STAGES-1];
    assign sdaClean = sdaSync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclPrev_q <= sclClean;
            sdaPrev_q <= sdaClean;
        end
    end

    assign sclRise  = sclClean & ~sclPrev_q;
    assign sclFall  = ~sclClean & sclPrev_q;
    assign startDet = sclPrev_q & sclClean & sdaPrev_q & ~sdaClean;
    assign stopDet  = sclPrev_q & sclClean & ~sdaPrev_q & sdaClean;
    assign shiftIn  = {shift_q[6:0], sdaClean};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitCnt_q  <= 3'd7;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            sdaOen_q  <= 1'b0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
            txReq_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            sdaOen_q  <= sdaOen_d;
            rxData_q  <= rxData_d;
            rxValid_q <= rxValid_d;
            txReq_q   <= txReq_d;
            busy_q    <= busy_d;
        end
    end

    // In the ACK states the current enable tells which SCL fall this is:
    // released means the ACK slot is starting, driven means it is ending.
    // For reads, the final bit is released by the first SCL fall in RD_ACK.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        sdaOen_d  = sdaOen_q;
        rxData_d  = rxData_q;
        rxValid_d = 1'b0;
        txReq_d   = 1'b0;
        busy_d    = busy_q;

        if (txReq_q) begin
            shift_d = tx_data;
        end

        if (stopDet) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            sdaOen_d = 1'b0;
        end else if (startDet) begin
            state_d  = ST_ADDR;
            bitCnt_d = 3'd7;
            sdaOen_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (sclRise) begin
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q - 3'd1;
                        if (bitCnt_q == 3'd0) begin
                            rw_d = sdaClean;
                            if (shiftIn[7:1] == ADDR) begin
                                busy_d  = 1'b1;
                                txReq_d = sdaClean;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (sclFall) begin
                        if (!sdaOen_q) begin
                            sdaOen_d = 1'b1;
                        end else if (rw_q) begin
                            sdaOen_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            state_d  = ST_RD_BYTE;
                        end else begin
                            sdaOen_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (sclRise) begin
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q - 3'd1;
                        if (bitCnt_q == 3'd0) begin
                            rxData_d  = shiftIn;
                            rxValid_d = 1'b1;
                            state_d   = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (sclFall) begin
                        if (!sdaOen_q) begin
                            sdaOen_d = 1'b1;
                        end else begin
                            sdaOen_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (sclRise) begin
                        bitCnt_d = bitCnt_q - 3'd1;
                        if (bitCnt_q == 3'd0) begin
                            state_d = ST_RD_ACK;
                        end
                    end else if (sclFall) begin
                        sdaOen_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    if (sclFall) begin
                        sdaOen_d = 1'b0;
                    end else if (sclRise) begin
                        if (!sdaClean) begin
                            txReq_d = 1'b1;
                            state_d = ST_RD_BYTE;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    sdaOen_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_o_en = sdaOen_q;
    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign tx_req   = txReq_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx
// Self-checking bench for i2c_target_rx. A bit-level I2C master drives the
// bus (wired-AND with the target's open-drain enable). Expected results come
// from transaction-level rules: the address byte is acknowledged only when
// its upper seven bits equal the target address, written bytes reappear on
// rx_data in order, read bytes return the fabric bytes, and busy follows
// the match and the STOP.
module tb_i2c_target_rx;

    localparam int         Q        = 10;
    localparam logic [6:0] TGT_ADDR = 7'h3C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclM, sdaM;
    logic       scl_i, sda_i;
    logic       sda_o_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int rxCount    = 0;
    int txReqCount = 0;
    int bothCount  = 0;
    int oenCount   = 0;
    int startCount = 0;
    logic [7:0] rxLog[$];
    logic [7:0] payload[$];

    assign scl_i = sclM;
    assign sda_i = sdaM & ~sda_o_en;

    i2c_target_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_o_en (sda_o_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse and event monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxCount++;
            rxLog.push_back(rx_data);
        end
        if (tx_req) txReqCount++;
        if (rx_valid && tx_req) bothCount++;
        if (sda_o_en) oenCount++;
        if (dut.startDet) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sclV, input logic sdaV, input int clks);
        sclM = sclV;
        sdaM = sdaV;
        repeat (clks) @(negedge clk);
    endtask

    // One SCL period starting just after a falling edge; returns the bus
    // value seen in the middle of the high phase.
    task automatic sendBit(input logic b, output logic seen);
        applyStimulus(1'b0, sdaM, Q);
        applyStimulus(1'b0, b, Q);
        applyStimulus(1'b1, b, Q);
        seen = sda_i;
        applyStimulus(1'b1, b, Q);
        sclM = 1'b0;
    endtask

    task automatic sendStart();
        applyStimulus(sclM, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b0, 1'b0, Q);
    endtask

    task automatic sendStop();
        applyStimulus(1'b0, 1'b0, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b1, 1'b1, Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ackSeen);
        logic dummy;
        for (int i = 7; i >= 0; i--) sendBit(b[i], dummy);
        sendBit(1'b1, ackSeen);
    endtask

    task automatic readByte(input logic nack, input logic [7:0] nextTx, output logic [7:0] data);
        logic v;
        logic dummy;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, v);
            data[i] = v;
        end
        tx_data = nextTx;
        sendBit(nack, dummy);
    endtask

    // Full START / address / payload / STOP transfer checked against the
    // transaction-level expectations. Reads ACK every byte but the last.
    task automatic runTransfer(input logic [7:0] addrByte, input string tag);
        logic       matched, seen;
        logic [7:0] got, nextTx;
        logic [31:0] obs;
        int baseTx, baseOen, baseLog, n;
        n       = payload.size();
        matched = (addrByte[7:1] == TGT_ADDR);
        baseTx  = txReqCount;
        baseOen = oenCount;
        baseLog = rxLog.size();
        if (addrByte[0]) tx_data = payload[0];
        sendStart();
        writeByte(addrByte, seen);
        checkOutput({tag, " addr ack"}, 32'(seen), 32'(!matched));
        for (int i = 0; i < n; i++) begin
            if (addrByte[0]) begin
                nextTx = (i + 1 < n) ? payload[i+1] : 8'h00;
                readByte(i == n - 1, nextTx, got);
                checkOutput($sformatf("%s rd byte %0d", tag, i), 32'(got),
                            matched ? 32'(payload[i]) : 32'hFF);
            end else begin
                writeByte(payload[i], seen);
                checkOutput($sformatf("%s wr ack %0d", tag, i), 32'(seen), 32'(!matched));
            end
        end
        checkOutput({tag, " rx count"}, 32'(rxLog.size() - baseLog),
                    (matched && !addrByte[0]) ? 32'(n) : 32'd0);
        if (matched && !addrByte[0]) begin
            for (int i = 0; i < n; i++) begin
                obs = (rxLog.size() > baseLog + i) ? 32'(rxLog[baseLog+i]) : 'x;
                checkOutput($sformatf("%s rx data %0d", tag, i), obs, 32'(payload[i]));
            end
        end
        checkOutput({tag, " tx_req count"}, 32'(txReqCount - baseTx),
                    (matched && addrByte[0]) ? 32'(n) : 32'd0);
        if (!matched) checkOutput({tag, " sda never driven"}, 32'(oenCount - baseOen), 32'd0);
        checkOutput({tag, " busy before stop"}, 32'(busy), 32'(matched));
        sendStop();
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput({tag, " busy after stop"}, 32'(busy), 32'd0);
        checkOutput({tag, " sda released"}, 32'(sda_o_en), 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] got;
        int         baseTx, baseStart;

        rst_n   = 1'b0;
        tx_data = 8'h00;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("reset sda_o_en", 32'(sda_o_en), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset tx_req", 32'(tx_req), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 5);

        $display("[TB] write 0x78 A5 5A");
        payload = {8'hA5, 8'h5A};
        runTransfer(8'h78, "wr78");

        $display("[TB] write to 0x3D");
        payload = {8'h12, 8'h34};
        runTransfer(8'h7A, "wr7A");

        $display("[TB] read 0x79 C3 81");
        payload = {8'hC3, 8'h81};
        runTransfer(8'h79, "rd79");

        $display("[TB] write then repeated START read");
        baseTx = txReqCount;
        sendStart();
        writeByte(8'h78, seen);
        checkOutput("rs addr ack", 32'(seen), 32'd0);
        writeByte(8'h11, seen);
        checkOutput("rs data ack", 32'(seen), 32'd0);
        checkOutput("rs rx_data", 32'(rx_data), 32'h11);
        tx_data = 8'h96;
        sendStart();
        checkOutput("rs busy held", 32'(busy), 32'd1);
        writeByte(8'h79, seen);
        checkOutput("rs readdr ack", 32'(seen), 32'd0);
        readByte(1'b1, 8'h00, got);
        checkOutput("rs rd byte", 32'(got), 32'h96);
        checkOutput("rs tx_req count", 32'(txReqCount - baseTx), 32'd1);
        sendStop();
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("rs busy after stop", 32'(busy), 32'd0);

        $display("[TB] reset while driving a read 0 bit");
        tx_data = 8'h3F;
        sendStart();
        writeByte(8'h79, seen);
        checkOutput("rst addr ack", 32'(seen), 32'd0);
        applyStimulus(1'b0, 1'b1, 5);
        checkOutput("rst driving 0", 32'(sda_o_en), 32'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst sda released", 32'(sda_o_en), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 3);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 4 * Q);
        payload = {8'h42};
        runTransfer(8'h78, "postrst");

        $display("[TB] 1-clk SDA glitch in IDLE");
        baseStart = startCount;
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 2 * Q);
`ifdef I2C_TGT_GLITCH_FILTER_EN
        checkOutput("glitch start count", 32'(startCount - baseStart), 32'd0);
`else
        checkOutput("glitch start count", 32'(startCount - baseStart), 32'd1);
`endif
        checkOutput("glitch busy", 32'(busy), 32'd0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 6; t++) begin
            logic [6:0] addr7;
            logic       rw;
            int         n;
            if ($urandom_range(0, 1) == 1) begin
                addr7 = TGT_ADDR;
            end else begin
                do addr7 = 7'($urandom); while (addr7 == TGT_ADDR);
            end
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            payload = {};
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
            runTransfer({addr7, rw}, $sformatf("rnd%0d", t));
        end

        checkOutput("rx_valid and tx_req overlap", 32'(bothCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
